seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-cathode
// seven-segment display. Feeds one BCD nibble at a time to a shared decoder,
// drives the one-hot digit enable with a programmable on-time and a fixed
// dead time between digits. Display data is double-buffered and swapped in
// at a frame boundary (or immediately while idle).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | scan disabled, outputs dark, idx and prescaler held at 0
// SHOW    | digit idx lit for div_val+1 cycles (unless blanked)
// GAP     | dead time of GAP_CYCLES cycles, all digits dark
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int GAP_CYCLES = 2
) (
`ifdef USE_POWER_PINS
  inout  wire                      vdd,
  inout  wire                      vss,
`endif
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     en,
  input  logic [DIV_WIDTH-1:0]     div_val,
  input  logic [NUM_DIGITS-1:0]    blank_mask,
  input  logic [4*NUM_DIGITS-1:0]  load_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic [3:0]               bcd_o,
  output logic [NUM_DIGITS-1:0]    dig_en_o,
  output logic                     seg_blank_o,
  output logic                     frame_o
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIV_WIDTH-1:0]    presc_q, presc_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pend_q, pend_d;
  logic [3:0]              bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    blank_q, blank_d;
  logic                    frame_q, frame_d;
  logic                    wrap;
  logic                    accept;
  logic [3:0]              nib;

  assign load_ready = ~pend_q & ~wb_rst_i;
  assign accept     = load_valid & load_ready;

  // Scan sequencing: SHOW on-time via prescaler, GAP dead time via down-counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    gap_d   = gap_q;
    wrap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d   = '0;
        presc_d = '0;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        // equality only: lowering div_val below presc runs to counter wrap
        if (presc_q == div_val) begin
          presc_d = '0;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_SHOW;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      presc_d = '0;
      wrap    = 1'b0;
    end
  end

  // Double buffer: apply shadow at frame wrap or while idle, then accept new data.
  always_comb begin
    active_d = active_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (pend_q && (wrap || state_q == ST_IDLE)) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end
    if (accept) begin
      shadow_d = load_data;
      pend_d   = 1'b1;
    end
  end

  // Output decode from next state so registered outputs line up with the state.
  always_comb begin
    nib     = active_d[{idx_d, 2'b00} +: 4];
    bcd_d   = bcd_q;
    dig_d   = '0;
    blank_d = 1'b1;
    frame_d = wrap;
    if (state_d == ST_SHOW) begin
      bcd_d = nib;
      if (!blank_mask[idx_d] && nib <= 4'd9) begin
        dig_d[idx_d] = 1'b1;
        blank_d      = 1'b0;
      end
    end
  end

  // State, buffers and registered outputs with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      presc_q  <= '0;
      gap_q    <= '0;
      active_q <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      bcd_q    <= 4'd0;
      dig_q    <= '0;
      blank_q  <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      presc_q  <= presc_d;
      gap_q    <= gap_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      bcd_q    <= bcd_d;
      dig_q    <= dig_d;
      blank_q  <= blank_d;
      frame_q  <= frame_d;
    end
  end

  assign bcd_o       = bcd_q;
  assign dig_en_o    = dig_q;
  assign seg_blank_o = blank_q;
  assign frame_o     = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: two instances (dead time 2 and 1) share the
// stimulus; a slot-position model predicts every output each cycle, and
// directed literal checks pin the model at key points.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div_val;
  logic [3:0]  mask;
  logic [15:0] ld;
  logic        lv;

  logic       rdy_a, rdy_b;
  logic [3:0] bcd_a, bcd_b;
  logic [3:0] dig_a, dig_b;
  logic       blank_a, blank_b;
  logic       frame_a, frame_b;

`ifdef USE_POWER_PINS
  wire vdd = 1'b1;
  wire vss = 1'b0;
`endif

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(4), .DIV_WIDTH(16), .GAP_CYCLES(2)) dut_a (
`ifdef USE_POWER_PINS
    .vdd(vdd), .vss(vss),
`endif
    .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .div_val(div_val),
    .blank_mask(mask), .load_data(ld), .load_valid(lv), .load_ready(rdy_a),
    .bcd_o(bcd_a), .dig_en_o(dig_a), .seg_blank_o(blank_a), .frame_o(frame_a));

  seg_scan_ctrl #(.NUM_DIGITS(4), .DIV_WIDTH(16), .GAP_CYCLES(1)) dut_b (
`ifdef USE_POWER_PINS
    .vdd(vdd), .vss(vss),
`endif
    .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .div_val(div_val),
    .blank_mask(mask), .load_data(ld), .load_valid(lv), .load_ready(rdy_b),
    .bcd_o(bcd_b), .dig_en_o(dig_b), .seg_blank_o(blank_b), .frame_o(frame_b));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each digit owns a slot of div_val+1+gap cycles; lit for the first div_val+1.
  bit         m_run   [2];
  bit         m_pend  [2];
  int         m_dig   [2];
  int         m_pos   [2];
  logic [15:0] m_shadow[2];
  logic [3:0] m_act   [2][4];
  logic [3:0] e_dig   [2];
  logic [3:0] e_bcd   [2];
  bit         e_blank [2];
  bit         e_frame [2];

  always @(posedge clk) begin
    bit was_idle, wrap, acc;
    int g;
    for (int i = 0; i < 2; i++) begin
      g = (i == 0) ? 2 : 1;
      if (rst) begin
        m_run[i] = 0; m_pend[i] = 0; m_dig[i] = 0; m_pos[i] = 0;
        m_shadow[i] = '0;
        for (int k = 0; k < 4; k++) m_act[i][k] = 4'd0;
        e_dig[i] = 4'd0; e_bcd[i] = 4'd0; e_blank[i] = 1; e_frame[i] = 0;
      end else begin
        acc      = lv && !m_pend[i];
        was_idle = !m_run[i];
        wrap     = 0;
        if (!en) begin
          m_run[i] = 0; m_dig[i] = 0; m_pos[i] = 0;
        end else if (was_idle) begin
          m_run[i] = 1; m_dig[i] = 0; m_pos[i] = 0;
        end else begin
          m_pos[i]++;
          if (m_pos[i] == int'(div_val) + 1 + g) begin
            m_pos[i] = 0;
            m_dig[i] = (m_dig[i] + 1) % 4;
            wrap = (m_dig[i] == 0);
          end
        end
        if (m_pend[i] && (wrap || was_idle)) begin
          for (int k = 0; k < 4; k++) m_act[i][k] = m_shadow[i][4*k +: 4];
          m_pend[i] = 0;
        end
        if (acc) begin
          m_shadow[i] = ld;
          m_pend[i]   = 1;
        end
        e_frame[i] = wrap;
        if (m_run[i] && m_pos[i] <= int'(div_val)) begin
          e_bcd[i] = m_act[i][m_dig[i]];
          if (mask[m_dig[i]] || e_bcd[i] > 4'd9) begin
            e_dig[i] = 4'd0; e_blank[i] = 1;
          end else begin
            e_dig[i] = 4'd1 << m_dig[i]; e_blank[i] = 0;
          end
        end else begin
          e_dig[i] = 4'd0; e_blank[i] = 1;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a dig_en", int'(dig_a), int'(e_dig[0]));
      cmp("a bcd", int'(bcd_a), int'(e_bcd[0]));
      cmp("a seg_blank", int'(blank_a), int'(e_blank[0]));
      cmp("a frame", int'(frame_a), int'(e_frame[0]));
      cmp("a load_ready", int'(rdy_a), int'(!m_pend[0] && !rst));
      cmp("a onehot0", int'($onehot0(dig_a)), 1);
      cmp("b dig_en", int'(dig_b), int'(e_dig[1]));
      cmp("b bcd", int'(bcd_b), int'(e_bcd[1]));
      cmp("b seg_blank", int'(blank_b), int'(e_blank[1]));
      cmp("b frame", int'(frame_b), int'(e_frame[1]));
      cmp("b load_ready", int'(rdy_b), int'(!m_pend[1] && !rst));
      cmp("b onehot0", int'($onehot0(dig_b)), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_frame(input int which);
    int n = 0;
    do begin
      tick();
      n++;
    end while (((which == 0) ? frame_a : frame_b) !== 1'b1 && n < 200);
    if (n >= 200) cmp("wait_frame timeout", 0, 1);
  endtask

  task automatic frame_period(input int which, output int n);
    wait_frame(which);
    n = 0;
    do begin
      tick();
      n++;
    end while (((which == 0) ? frame_a : frame_b) !== 1'b1 && n < 200);
  endtask

  initial begin
    int per;
    rst = 1; en = 0; div_val = 16'd3; mask = 4'b0000; ld = '0; lv = 0;
    tick();
    chk_en = 1;
    tick(); tick();
    // reset state
    cmp("rst dig_en", int'(dig_a), 0);
    cmp("rst seg_blank", int'(blank_a), 1);
    cmp("rst bcd", int'(bcd_a), 0);
    cmp("rst frame", int'(frame_a), 0);
    cmp("rst load_ready", int'(rdy_a), 0);
    rst = 0;
    #1 cmp("post-rst load_ready", int'(rdy_a), 1);

    // 1: load 0x4321, start scan
    lv = 1; ld = 16'h4321;
    tick();
    lv = 0;
    #1 cmp("t1 ready after accept", int'(rdy_a), 0);
    tick();
    cmp("t1 ready after apply", int'(rdy_a), 1);
    en = 1;
    tick();
    cmp("t1 d0 dig_en", int'(dig_a), 1);
    cmp("t1 d0 bcd", int'(bcd_a), 1);
    cmp("t1 d0 blank", int'(blank_a), 0);
    repeat (3) tick();
    cmp("t1 d0 4th cycle", int'(dig_a), 1);
    tick();
    cmp("t1 gap dig_en", int'(dig_a), 0);
    cmp("t1 gap blank", int'(blank_a), 1);
    cmp("t1 gap bcd held", int'(bcd_a), 1);
    tick(); tick();
    cmp("t1 d1 dig_en", int'(dig_a), 2);
    cmp("t1 d1 bcd", int'(bcd_a), 2);
    frame_period(0, per);
    cmp("t1 frame period", per, 24);
    cmp("t1 wrap bcd", int'(bcd_a), 1);

    // 2: load 0x8765 during digit 1, takes effect at next wrap
    repeat (6) tick();
    lv = 1; ld = 16'h8765;
    tick();
    lv = 0;
    #1 cmp("t2 ready held low", int'(rdy_a), 0);
    repeat (5) tick();
    cmp("t2 d2 dig_en", int'(dig_a), 4);
    cmp("t2 d2 old bcd", int'(bcd_a), 3);
    repeat (6) tick();
    cmp("t2 d3 old bcd", int'(bcd_a), 4);
    wait_frame(0);
    cmp("t2 new d0 bcd", int'(bcd_a), 5);
    cmp("t2 ready on wrap", int'(rdy_a), 1);

    // 3: blanking by mask and by out-of-range nibble
    mask = 4'b0100; lv = 1; ld = 16'hA909;
    tick();
    lv = 0;
    wait_frame(0);
    cmp("t3 d0 bcd", int'(bcd_a), 9);
    cmp("t3 d0 dig_en", int'(dig_a), 1);
    repeat (6) tick();
    cmp("t3 d1 bcd", int'(bcd_a), 0);
    cmp("t3 d1 dig_en", int'(dig_a), 2);
    repeat (6) tick();
    cmp("t3 d2 masked dig_en", int'(dig_a), 0);
    cmp("t3 d2 masked blank", int'(blank_a), 1);
    repeat (6) tick();
    cmp("t3 d3 hex dig_en", int'(dig_a), 0);
    cmp("t3 d3 hex blank", int'(blank_a), 1);
    cmp("t3 d3 hex bcd", int'(bcd_a), 10);

    // 4: drop en during digit 2 SHOW, restart at digit 0
    mask = 4'b0000;
    wait_frame(0);
    repeat (12) tick();
    cmp("t4 d2 dig_en", int'(dig_a), 4);
    tick();
    en = 0;
    tick();
    cmp("t4 off dig_en", int'(dig_a), 0);
    cmp("t4 off blank", int'(blank_a), 1);
    cmp("t4 off frame", int'(frame_a), 0);
    tick(); tick();
    en = 1;
    tick();
    cmp("t4 restart dig_en", int'(dig_a), 1);
    cmp("t4 restart bcd", int'(bcd_a), 9);
    repeat (3) tick();
    cmp("t4 full on-time", int'(dig_a), 1);
    tick();
    cmp("t4 gap after restart", int'(dig_a), 0);

    // 5: reset mid-GAP with a load pending on the bus
    lv = 1; ld = 16'h1234; rst = 1;
    #1 cmp("t5 ready in reset", int'(rdy_a), 0);
    tick();
    cmp("t5 rst dig_en", int'(dig_a), 0);
    cmp("t5 rst bcd", int'(bcd_a), 0);
    cmp("t5 rst blank", int'(blank_a), 1);
    rst = 0; lv = 0;
    #1 cmp("t5 ready after reset", int'(rdy_a), 1);
    tick();
    cmp("t5 zero data dig_en", int'(dig_a), 1);
    cmp("t5 zero data bcd", int'(bcd_a), 0);
    repeat (30) tick();

    // 6: shortest on-time, both dead times
    en = 0;
    tick();
    div_val = 16'd0; en = 1;
    frame_period(1, per);
    cmp("t6 b frame period", per, 8);
    frame_period(0, per);
    cmp("t6 a frame period", per, 12);
    for (int c = 0; c < 1000; c++) begin
      en   = ($urandom_range(0, 19) != 0);
      lv   = $urandom_range(0, 1) != 0;
      ld   = 16'($urandom);
      mask = 4'($urandom_range(0, 15));
      tick();
    end
    lv = 0;
    tick();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
